serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor computing D = X − Y for WIDTH-bit operands, one bit per clock, LSB first, behind valid/ready handshakes on both sides. It pairs with the parallel-prefix `adder` in the arithmetic datapath. It trades latency for area and returns the difference together with borrow-out and signed-overflow flags. Its result must match the adder's result for X + ~Y + 1.

## Interface
- WIDTH, 6, operand and result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands X, Y valid
- in_ready  out  1  block can accept operands
- X  in  WIDTH  minuend
- Y  in  WIDTH  subtrahend
- out_valid  out  1  result D, bout, ovf valid
- out_ready  in  1  consumer accepts result
- D  out  WIDTH  difference, X − Y mod 2^WIDTH
- bout  out  1  borrow out, 1 iff X < Y unsigned
- ovf  out  1  signed overflow of X − Y

## Operation
- **States.**
  - IDLE → SHIFT on the accept edge (in_valid & in_ready).
  - SHIFT → DONE after WIDTH bit-steps.
  - DONE → IDLE on the output handshake (out_valid & out_ready).
- **Accept.** On the accept edge, the block latches X and Y into shift registers, clears the borrow flop to 0, clears the bit counter to 0, and clears the D shift register.
- **Bit-step (SHIFT, once per clock).**
  - Inputs: x = X_sr[0], y = Y_sr[0], b = borrow.
  - d = x ^ y ^ b.
  - b' = (~x & y) | (~(x ^ y) & b).
  - d is shifted into the D register from the MSB side.
  - X_sr and Y_sr shift right by one.
  - The counter increments.
- **MSB step.** On the step with counter = WIDTH−1:
  - ovf ← (x ^ y) & (x ^ d).
  - bout ← b'.
  - State moves to DONE.
- **Output hold.** D, bout and ovf are held stable while out_valid = 1 and out_ready = 0.
- **Handshake signals.**
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
  - in_valid is ignored outside IDLE; X and Y may change freely after acceptance.
- **Reset.**
  - rst_n low at any time, including mid-SHIFT, forces state to IDLE and clears the borrow and counter flops.
  - The in-flight result is lost; no out_valid is produced for it.
- **Reset values.** in_ready = 1 (combinational from IDLE); out_valid = 0; D = 0; bout = 0; ovf = 0.

## Timing
- **Latency.**
  - The accept edge is edge A.
  - Bit i is processed at edge A+1+i.
  - out_valid rises after edge A+WIDTH (cycle A+WIDTH+1), i.e. WIDTH cycles after the accept edge.
- **Throughput.**
  - With out_ready held at 1, the output handshake completes at edge A+WIDTH+1.
  - in_ready reasserts in the following cycle.
  - The next accept is at the earliest at edge A+WIDTH+2, so one result per WIDTH+2 cycles.
- **Backpressure.** With out_ready = 0, the block stays in DONE indefinitely with outputs frozen and in_ready = 0.
- **Cross-side signals.** There are no combinational paths from in_valid to in_ready, or from out_ready to out_valid. in_ready and out_valid decode from state flops only.
- **Counter.** The bit counter is $clog2(WIDTH) bits wide. Wrap-around is not possible, because the counter is cleared on accept and compared against WIDTH−1.

## Structure
- **Shared package `arith_pkg`:**
  - state enum {IDLE, SHIFT, DONE};
  - localparam DEFAULT_WIDTH = 6;
  - counter-width function.
- **Sub-module `fs_cell`:** combinational 1-bit full subtractor.
  - Inputs: x, y, bin.
  - Outputs: d, bout.
  - Instantiated once; the top level holds all sequential logic.

## Test plan
- **Basic subtract.** X=45, Y=12, out_ready=1 → D=33, bout=0, ovf=0. out_valid is high exactly 6 cycles after the accept edge, for 1 cycle.
- **Negative unsigned result.** X=12, Y=45 → D=31, bout=1, ovf=0.
- **Underflow and overflow.**
  - X=0, Y=1 → D=63, bout=1, ovf=0.
  - X=32, Y=1 → D=31, bout=0, ovf=1 (−32−1 overflows).
- **Backpressure.**
  - Setup: out_ready=0 for 10 cycles after out_valid rises, with in_valid=1 and new operands applied.
  - Required: D, bout and ovf stay frozen; in_ready=0; no second accept occurs.
  - After out_ready=1: handshake completes, the next accept occurs 1 cycle later, and the second result is correct.
- **Reset mid-operation.** Assert rst_n=0 for 1 cycle at bit-step 3 of X=63, Y=0 → in_ready=1, out_valid=0 and D=0 immediately. A following op X=5, Y=7 → D=62, bout=1.
- **Reference compare.** Run 1000 random operand pairs back-to-back, with random out_ready stalls, against X + ~Y + 1 from the `adder` model → every D, bout and ovf matches. Output count equals accept count.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic datapath.
`timescale 1ns/1ps
package arith_pkg;

    // Sequencer states of the serial arithmetic units.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 6;

    // Width of a counter that must reach w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, with borrow out.
`timescale 1ns/1ps
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when y exceeds x, or when they are equal and a borrow comes in.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = X - Y, one bit per clock, LSB
// first, with valid/ready handshakes on the operand and result sides.
`timescale 1ns/1ps
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_x_sr;
    logic [WIDTH-1:0] r_y_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bout;
    logic             r_ovf;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_b;
    logic             w_last;

    assign w_x    = r_x_sr[0];
    assign w_y    = r_y_sr[0];
    assign w_last = (r_cnt == LAST_BIT);

    fs_cell u_fs_cell (
        .x    (w_x),
        .y    (w_y),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_b)
    );

    // Handshake flags decode from the state flop only, so neither side sees a
    // combinational path from the other.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign D         = r_d_sr;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

    // Sequencer and datapath: accept operands, step one bit per clock, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too, because D, bout and
            // ovf are visible outputs with defined values straight after reset.
            r_state  <= IDLE;
            r_x_sr   <= '0;
            r_y_sr   <= '0;
            r_d_sr   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side reads the pre-edge value and the shift chains move as one.
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x_sr   <= X;
                        r_y_sr   <= Y;
                        r_d_sr   <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_d_sr   <= {w_d, r_d_sr[WIDTH-1:1]};
                    r_x_sr   <= r_x_sr >> 1;
                    r_y_sr   <= r_y_sr >> 1;
                    r_borrow <= w_b;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // Signed overflow: operand signs differ and the result
                        // sign differs from the minuend sign.
                        r_ovf   <= (w_x ^ w_y) & (w_x ^ w_d);
                        r_bout  <= w_b;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus a
// randomized run scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int W    = 6;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         bout;
    logic         ovf;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_out = 0;
    int n_lost = 0;

    logic [2*W-1:0] q[$];
    logic           hold_pend = 1'b0;
    logic [W-1:0]   hold_d;
    logic           hold_b;
    logic           hold_o;
    logic           rnd_done;

    serial_subtractor #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: the adder form X + ~Y + 1, unsigned compare, signed range test.
    function automatic void ref_sub(input int x, input int y,
                                    output int d, output int b, output int o);
        int sx, sy, sd;
        d  = (x + ((~y) & MASK) + 1) & MASK;
        b  = (x < y) ? 1 : 0;
        sx = (x >= HALF) ? x - (1 << W) : x;
        sy = (y >= HALF) ? y - (1 << W) : y;
        sd = sx - sy;
        o  = (sd < -HALF || sd > HALF - 1) ? 1 : 0;
    endfunction

    // Scoreboard: observe both handshakes mid-cycle, when all signals are settled.
    always @(negedge clk) begin
        int ed, eb, eo;
        logic [2*W-1:0] ent;
        if (!rst_n) begin
            n_lost += q.size();
            q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && out_valid) begin
                check("hold_D", int'(D), int'(hold_d));
                check("hold_bout", int'(bout), int'(hold_b));
                check("hold_ovf", int'(ovf), int'(hold_o));
            end
            hold_pend = out_valid && !out_ready;
            hold_d = D;
            hold_b = bout;
            hold_o = ovf;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", int'(out_valid), 0);
                end else begin
                    ent = q.pop_front();
                    ref_sub(int'(ent[2*W-1:W]), int'(ent[W-1:0]), ed, eb, eo);
                    check("sb_D", int'(D), ed);
                    check("sb_bout", int'(bout), eb);
                    check("sb_ovf", int'(ovf), eo);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back({X, Y});
                n_acc++;
            end
        end
    end

    // Present operands and hold in_valid until accepted; returns just after the accept edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit drop);
        X = x;
        Y = y;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check("accept_timeout", int'(in_ready), 1);
        @(posedge clk);
        #1;
        if (drop) in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid and compare the presented result.
    task automatic wait_result(input string tag, input int ed, input int eb, input int eo);
        for (int i = 0; i < 50; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_D"}, int'(D), ed);
        check({tag, "_bout"}, int'(bout), eb);
        check({tag, "_ovf"}, int'(ovf), eo);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish before 900 us");
        $fatal(1);
    end

    initial begin
        logic any_valid;
        int   acc0;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        X = '0;
        Y = '0;
        rnd_done = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_D", int'(D), 0);
        check("rst_bout", int'(bout), 0);
        check("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic subtract with exact latency: out_valid for one cycle, 6 edges after accept.
        send(6'd45, 6'd12, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat_out_valid_%0d", k), int'(out_valid), (k == 6) ? 1 : 0);
            check($sformatf("lat_in_ready_%0d", k), int'(in_ready), (k >= 7) ? 1 : 0);
            if (k == 6) begin
                check("basic_D", int'(D), 33);
                check("basic_bout", int'(bout), 0);
                check("basic_ovf", int'(ovf), 0);
            end
        end

        // Negative unsigned result, underflow, signed overflow.
        send(6'd12, 6'd45, 1'b1);
        wait_result("neg", 31, 1, 0);
        send(6'd0, 6'd1, 1'b1);
        wait_result("under", 63, 1, 0);
        send(6'd32, 6'd1, 1'b1);
        wait_result("ovf", 31, 0, 1);
        @(posedge clk);
        #1;

        // Backpressure: result frozen, no second accept while stalled.
        out_ready = 1'b0;
        send(6'd20, 6'd50, 1'b1);
        wait_result("bp_first", 34, 1, 1);
        X = 6'd7;
        Y = 6'd3;
        in_valid = 1'b1;
        acc0 = n_acc;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_D", int'(D), 34);
            check("bp_bout", int'(bout), 1);
            check("bp_ovf", int'(ovf), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
        end
        check("bp_no_accept", n_acc, acc0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        check("bp_next_accept_in_ready", int'(in_ready), 0);
        check("bp_next_accept_count", n_acc, acc0 + 1);
        in_valid = 1'b0;
        wait_result("bp_second", 4, 0, 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a shift: in-flight result is dropped.
        send(6'd63, 6'd0, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_D", int'(D), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        any_valid = 1'b0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            any_valid |= out_valid;
        end
        check("mid_rst_no_result", int'(any_valid), 0);
        send(6'd5, 6'd7, 1'b1);
        wait_result("post_rst", 62, 1, 0);
        @(posedge clk);
        #1;

        // Randomized back-to-back operands with random result stalls.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    send(W'($urandom), W'($urandom), $urandom_range(0, 3) == 0);
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", q.size(), 0);
        check("accepts_vs_outputs", n_acc, n_out + n_lost);
        check("lost_in_reset", n_lost, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
